// File: rtl/mem_stage_controller.sv
// M-stage data-memory sequencer: drives a req/gnt/rvalid bus for the instruction
// held in EX/MEM, stalls the upstream pipeline and bubbles writeback while an
// access is in flight, and aborts accesses that exceed a cycle budget.
module mem_stage_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_MemReadM,
    input  logic        i_MemWriteM,
    input  logic [31:0] i_ALUResultM,
    input  logic [31:0] i_WriteDataM,
    input  logic [3:0]  i_ByteEnM,
    output logic        o_MemReq,
    output logic        o_MemWe,
    output logic [31:0] o_MemAddr,
    output logic [31:0] o_MemWData,
    output logic [3:0]  o_MemBe,
    input  logic        i_MemGnt,
    input  logic        i_MemRValid,
    input  logic [31:0] i_MemRData,
    output logic [31:0] o_ReadDataM,
    output logic        o_StallM,
    output logic        o_FlushW,
    output logic        o_MemErr
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Counter value seen in the last REQ/WAIT cycle an access may occupy.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q,    be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                req_q,   req_d;
    logic                err_q,   err_d;

    logic                access_c;
    logic                timeout_c;
    logic                req_done_c;
    logic                stall_c;

    assign access_c  = i_MemReadM | i_MemWriteM;
    assign timeout_c = (cnt_q == CNT_LAST);

    // A granted store completes at once; a granted load completes only if its data is already back.
    assign req_done_c = i_MemGnt & (we_q | i_MemRValid);

    // State and datapath registers; reset aborts any in-flight access.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // Next-state, bus latching, load capture and timeout handling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access_c) begin
                    // Store wins when both read and write are flagged.
                    we_d    = i_MemWriteM;
                    addr_d  = i_ALUResultM;
                    wdata_d = i_WriteDataM;
                    be_d    = i_ByteEnM;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (req_done_c) begin
                    if (!we_q) begin
                        rdata_d = i_MemRData;
                    end
                    state_d = S_DONE;
                end else if (timeout_c) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (i_MemGnt) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_MemRValid) begin
                    rdata_d = i_MemRData;
                    state_d = S_DONE;
                end else if (timeout_c) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // M-stage inputs still describe the finished instruction here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Request is a registered decode of the state being entered.
        req_d = (state_d == S_REQ);
    end

    // Pipeline hold: a pending access in IDLE must stall in the same cycle it appears.
    assign stall_c = ((state_q == S_IDLE) & access_c) |
                     (state_q == S_REQ) |
                     (state_q == S_WAIT);

    assign o_MemReq    = req_q;
    assign o_MemWe     = we_q;
    assign o_MemAddr   = addr_q;
    assign o_MemWData  = wdata_q;
    assign o_MemBe     = be_q;
    assign o_ReadDataM = rdata_q;
    assign o_MemErr    = err_q;
    assign o_StallM    = stall_c;
    assign o_FlushW    = stall_c;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Bench for mem_stage_controller: directed and random accesses against a
// transaction-level model; a negedge monitor pops expectations per completed access.
module tb_mem_stage_controller;

    localparam int unsigned T = 4;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_MemReadM;
    logic        i_MemWriteM;
    logic [31:0] i_ALUResultM;
    logic [31:0] i_WriteDataM;
    logic [3:0]  i_ByteEnM;
    logic        o_MemReq;
    logic        o_MemWe;
    logic [31:0] o_MemAddr;
    logic [31:0] o_MemWData;
    logic [3:0]  o_MemBe;
    logic        i_MemGnt;
    logic        i_MemRValid;
    logic [31:0] i_MemRData;
    logic [31:0] o_ReadDataM;
    logic        o_StallM;
    logic        o_FlushW;
    logic        o_MemErr;

    mem_stage_controller #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_MemReadM   (i_MemReadM),
        .i_MemWriteM  (i_MemWriteM),
        .i_ALUResultM (i_ALUResultM),
        .i_WriteDataM (i_WriteDataM),
        .i_ByteEnM    (i_ByteEnM),
        .o_MemReq     (o_MemReq),
        .o_MemWe      (o_MemWe),
        .o_MemAddr    (o_MemAddr),
        .o_MemWData   (o_MemWData),
        .o_MemBe      (o_MemBe),
        .i_MemGnt     (i_MemGnt),
        .i_MemRValid  (i_MemRValid),
        .i_MemRData   (i_MemRData),
        .o_ReadDataM  (o_ReadDataM),
        .o_StallM     (o_StallM),
        .o_FlushW     (o_FlushW),
        .o_MemErr     (o_MemErr)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
        int          stall;
        int          req;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Memory-side behaviour for the current access
    int          txn_id     = 0;
    logic        cur_active = 1'b0;
    logic        cur_store  = 1'b0;
    int          cur_g      = 0;
    int          cur_r      = 0;
    logic [31:0] cur_rdata  = 32'h0;
    logic        rv_storm   = 1'b0;

    logic        mon_en      = 1'b0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Memory responder: grants after cur_g refused REQ cycles, returns load data cur_r cycles later,
    // and sprinkles rvalid noise wherever it must be ignored.
    int   r_seen = -1;
    int   r_idx  = 0;
    int   r_wcnt = 0;
    logic r_wait = 1'b0;
    initial begin
        i_MemGnt    = 1'b0;
        i_MemRValid = 1'b0;
        i_MemRData  = 32'h0;
        forever begin
            @(posedge i_Clk);
            #2;
            if (txn_id != r_seen) begin
                r_seen = txn_id;
                r_idx  = 0;
                r_wcnt = 0;
                r_wait = 1'b0;
            end
            i_MemGnt    = 1'b0;
            i_MemRValid = 1'b0;
            i_MemRData  = $urandom;
            if (cur_active && o_MemReq) begin
                if (r_idx == cur_g) begin
                    i_MemGnt = 1'b1;
                    if (cur_store) begin
                        i_MemRValid = ($urandom_range(0, 1) == 0);
                    end else if (cur_r == 0) begin
                        i_MemRValid = 1'b1;
                        i_MemRData  = cur_rdata;
                    end else begin
                        r_wait = 1'b1;
                    end
                end else begin
                    i_MemRValid = ($urandom_range(0, 2) == 0);
                end
                r_idx++;
            end else if (cur_active && r_wait) begin
                r_wcnt++;
                if (r_wcnt == cur_r) begin
                    i_MemRValid = 1'b1;
                    i_MemRData  = cur_rdata;
                    r_wait      = 1'b0;
                end
            end else begin
                i_MemRValid = rv_storm | ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: per-cycle invariants, and a full comparison each time an access completes.
    logic        m_prev_stall = 1'b0;
    logic        m_prev_req   = 1'b0;
    int          m_stall      = 0;
    int          m_req        = 0;
    logic [68:0] m_prev_bus   = '0;
    logic [68:0] m_bus_now;
    exp_t        m_e;
    initial begin
        forever begin
            @(negedge i_Clk);
            m_bus_now = {o_MemWe, o_MemAddr, o_MemWData, o_MemBe};
            if (!mon_en) begin
                m_prev_stall = 1'b0;
                m_prev_req   = 1'b0;
                m_stall      = 0;
                m_req        = 0;
            end else begin
                check("flush_eq_stall", 32'(o_FlushW), 32'(o_StallM));
                if (m_bus_now != m_prev_bus) begin
                    check("bus_changes_only_entering_req", 32'(o_MemReq && !m_prev_req), 32'd1);
                end
                if (m_prev_stall && !o_StallM) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_done: got completion expected none (t=%0t)", $time);
                    end else begin
                        m_e = exp_q.pop_front();
                        check("stall_cycles", 32'(m_stall), 32'(m_e.stall));
                        check("req_cycles",   32'(m_req),   32'(m_e.req));
                        check("bus_we",       32'(o_MemWe), 32'(m_e.we));
                        check("bus_addr",     o_MemAddr,    m_e.addr);
                        check("bus_wdata",    o_MemWData,   m_e.wdata);
                        check("bus_be",       32'(o_MemBe), 32'(m_e.be));
                        check("read_data",    o_ReadDataM,  m_e.rdata);
                        check("mem_err",      32'(o_MemErr), 32'(m_e.err));
                        check("req_low_in_done", 32'(o_MemReq), 32'd0);
                    end
                    m_stall = 0;
                    m_req   = 0;
                end else begin
                    check("err_only_in_done", 32'(o_MemErr), 32'd0);
                    if (o_StallM) m_stall++;
                    if (o_MemReq) m_req++;
                end
                m_prev_stall = o_StallM;
                m_prev_req   = o_MemReq;
            end
            m_prev_bus = m_bus_now;
        end
    end

    // Issue one access at posedge+1, push its expected outcome, and wait for the pipeline to advance.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           input int g, input int r, input logic [31:0] rdat);
        exp_t e;
        int   busy_need;
        bit   done;
        txn_id++;
        cur_active = 1'b1;
        cur_store  = wr;
        cur_g      = g;
        cur_r      = r;
        cur_rdata  = rdat;
        i_MemReadM   = rd;
        i_MemWriteM  = wr;
        i_ALUResultM = a;
        i_WriteDataM = d;
        i_ByteEnM    = be;

        busy_need = wr ? (g + 1) : (g + r + 1);
        e.err   = (busy_need > int'(T));
        e.stall = (e.err ? int'(T) : busy_need) + 1;
        e.req   = (g + 1 < int'(T)) ? (g + 1) : int'(T);
        e.we    = wr;
        e.addr  = a;
        e.wdata = d;
        e.be    = be;
        if (e.err)     model_rdata = 32'h0;
        else if (!wr)  model_rdata = rdat;
        e.rdata = model_rdata;
        exp_q.push_back(e);

        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge i_Clk);
            #1;
            if (!o_StallM) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL access_completion: got no completion expected one within 60 cycles");
            finish_sim();
        end
    endtask

    task automatic idle(input int n);
        i_MemReadM  = 1'b0;
        i_MemWriteM = 1'b0;
        cur_active  = 1'b0;
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    int          kind;
    int          gap;
    logic [31:0] ra;
    bit          saw_req;
    bit          in_wait;

    initial begin
        i_Reset      = 1'b1;
        i_MemReadM   = 1'b0;
        i_MemWriteM  = 1'b0;
        i_ALUResultM = 32'h0;
        i_WriteDataM = 32'h0;
        i_ByteEnM    = 4'h0;
        #2 i_Reset = 1'b0;
        #20;
        check("reset_req",   32'(o_MemReq),  32'd0);
        check("reset_we",    32'(o_MemWe),   32'd0);
        check("reset_addr",  o_MemAddr,      32'd0);
        check("reset_wdata", o_MemWData,     32'd0);
        check("reset_be",    32'(o_MemBe),   32'd0);
        check("reset_rdata", o_ReadDataM,    32'd0);
        check("reset_err",   32'(o_MemErr),  32'd0);
        check("reset_stall", 32'(o_StallM),  32'd0);
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b1;
        mon_en  = 1'b1;

        // Directed accesses
        run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0);
        run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 0, 3, 32'h1234_5678);
        run_txn(1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000, 4'h3, 0, 0, 32'hA5A5_A5A5);
        run_txn(1'b0, 1'b1, 32'h0000_0030, 32'h1111_2222, 4'hC, 100, 0, 32'h0);
        idle(1);
        run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h4040_4040, 4'hF, 0, 0, 32'h0);
        run_txn(1'b0, 1'b1, 32'h0000_0044, 32'h4444_4444, 4'h1, 0, 0, 32'h0);
        run_txn(1'b1, 1'b0, 32'h0000_0050, 32'h0,         4'hF, 3, 0, 32'h5A5A_0F0F);
        run_txn(1'b1, 1'b0, 32'h0000_0054, 32'h0,         4'hF, 1, 3, 32'h7777_7777);
        run_txn(1'b1, 1'b1, 32'h0000_0058, 32'hBEEF_0001, 4'h8, 1, 0, 32'h0);
        idle(2);

        // Random accesses
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            gap  = $urandom_range(0, 2);
            ra   = $urandom & 32'hFFFF_FFFC;
            run_txn((kind != 1) ? 1'b1 : 1'b0, (kind != 0) ? 1'b1 : 1'b0, ra, $urandom,
                    4'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 4), $urandom);
            if (gap != 0) idle(gap);
        end
        idle(2);

        // Reset in the middle of a load's WAIT phase
        mon_en = 1'b0;
        txn_id++;
        cur_active   = 1'b1;
        cur_store    = 1'b0;
        cur_g        = 0;
        cur_r        = 50;
        cur_rdata    = 32'hCAFE_F00D;
        i_MemReadM   = 1'b1;
        i_MemWriteM  = 1'b0;
        i_ALUResultM = 32'h0000_0080;
        i_ByteEnM    = 4'hF;
        saw_req = 1'b0;
        in_wait = 1'b0;
        for (int c = 0; c < 20 && !in_wait; c++) begin
            @(posedge i_Clk);
            #1;
            if (o_MemReq) saw_req = 1'b1;
            else if (saw_req && o_StallM) in_wait = 1'b1;
        end
        check("reached_wait_before_reset", 32'(in_wait), 32'd1);
        #2 i_Reset = 1'b0;
        #1;
        check("midreset_req",   32'(o_MemReq),  32'd0);
        check("midreset_addr",  o_MemAddr,      32'd0);
        check("midreset_we",    32'(o_MemWe),   32'd0);
        check("midreset_rdata", o_ReadDataM,    32'd0);
        check("midreset_err",   32'(o_MemErr),  32'd0);
        check("midreset_stall_idle_access", 32'(o_StallM), 32'd1);
        i_MemReadM = 1'b0;
        #1;
        check("midreset_idle_no_access", 32'(o_StallM), 32'd0);
        cur_active = 1'b0;
        rv_storm   = 1'b1;
        txn_id++;
        @(posedge i_Clk);
        #1;
        i_Reset = 1'b1;
        repeat (4) begin
            @(posedge i_Clk);
            #1;
            check("post_reset_rdata_ignores_rvalid", o_ReadDataM, 32'd0);
            check("post_reset_req",   32'(o_MemReq), 32'd0);
            check("post_reset_stall", 32'(o_StallM), 32'd0);
        end
        rv_storm    = 1'b0;
        model_rdata = 32'h0;
        mon_en      = 1'b1;

        // Controller resumes normally after the abort
        run_txn(1'b1, 1'b0, 32'h0000_0090, 32'h0,         4'hF, 1, 2, 32'h0BAD_CAFE);
        run_txn(1'b0, 1'b1, 32'h0000_0094, 32'h9494_9494, 4'hF, 2, 0, 32'h0);
        idle(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        finish_sim();
    end

endmodule
